// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// parks responses that arrive under a decode stall, and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [2:0]  dbg_state
);

    // imem handshake: imem_req is a one-cycle strobe raised only when nothing is
    // outstanding; the memory always accepts it and answers with exactly one
    // imem_rvalid pulse, no earlier than the cycle after the request.
    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
    logic        valid_d_q, valid_d_d;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_f_plus4;

    assign redirect_tgt = redirect_pc_e & ~32'h0000_0003;
    assign pc_f_plus4   = pc_f_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RESET;
            pc_f_q       <= RESET_PC;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            instr_d_q    <= NOP_INSTR;
            pc_d_q       <= 32'd0;
            pc_plus4_d_q <= 32'd0;
            valid_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_f_d        = pc_f_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        deliver       = 1'b0;
        deliver_instr = NOP_INSTR;
        deliver_pc    = pc_f_q;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_ISSUE;
                if (redirect_e) pc_f_d = redirect_tgt;
            end
            ST_ISSUE: begin
                // A redirect here lands after the request left, so its answer must be eaten.
                if (redirect_e) begin
                    pc_f_d  = redirect_tgt;
                    state_d = ST_DISCARD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_e) begin
                    pc_f_d  = redirect_tgt;
                    state_d = imem_rvalid ? ST_ISSUE : ST_DISCARD;
                end else if (imem_rvalid) begin
                    pc_f_d = pc_f_plus4;
                    if (stall_d) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_f_q;
                        state_d      = ST_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        deliver_pc    = pc_f_q;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect_e) pc_f_d = redirect_tgt;
                if (imem_rvalid) state_d = ST_ISSUE;
            end
            ST_HOLD: begin
                if (redirect_e) begin
                    skid_instr_d = 32'd0;
                    skid_pc_d    = 32'd0;
                    pc_f_d       = redirect_tgt;
                    state_d      = ST_ISSUE;
                end else if (!stall_d) begin
                    deliver       = 1'b1;
                    deliver_instr = skid_instr_q;
                    deliver_pc    = skid_pc_q;
                    state_d       = ST_ISSUE;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // IF/ID: flush beats stall; a stall freezes everything; otherwise load or bubble.
    always_comb begin
        instr_d_d    = instr_d_q;
        pc_d_d       = pc_d_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d_d    = valid_d_q;
        if (redirect_e) begin
            valid_d_d = 1'b0;
            instr_d_d = NOP_INSTR;
        end else if (!stall_d) begin
            if (deliver) begin
                instr_d_d    = deliver_instr;
                pc_d_d       = deliver_pc;
                pc_plus4_d_d = deliver_pc + 32'd4;
                valid_d_d    = 1'b1;
            end else begin
                instr_d_d = NOP_INSTR;
                valid_d_d = 1'b0;
            end
        end
    end

    assign imem_req   = (state_q == ST_ISSUE);
    assign imem_addr  = pc_f_q;
    assign instr_d    = instr_d_q;
    assign pc_d       = pc_d_q;
    assign pc_plus4_d = pc_plus4_d_q;
    assign valid_d    = valid_d_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset/startup, streaming at two latencies,
// stall into the skid register, redirect with a request in flight, flush vs stall, PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ST_RESET = 32'd0;
    localparam logic [31:0] ST_ISSUE = 32'd1;
    localparam logic [31:0] ST_WAIT  = 32'd2;
    localparam logic [31:0] ST_DISC  = 32'd3;
    localparam logic [31:0] ST_HOLD  = 32'd4;

    logic        clk;
    logic        rst;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;

    logic        d_req, w_req;
    logic [31:0] d_addr, w_addr;
    logic [31:0] d_instr, w_instr;
    logic [31:0] d_pc, w_pc;
    logic [31:0] d_pc4, w_pc4;
    logic        d_valid, w_valid;
    logic [2:0]  d_state, w_state;

    fetch_stage u_dut (
        .clk(clk), .rst(rst),
        .imem_req(d_req), .imem_addr(d_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
        .instr_d(d_instr), .pc_d(d_pc), .pc_plus4_d(d_pc4), .valid_d(d_valid),
        .dbg_state(d_state)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
        .instr_d(w_instr), .pc_d(w_pc), .pc_plus4_d(w_pc4), .valid_d(w_valid),
        .dbg_state(w_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running exp done");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          overlap  = 0;
    logic        sel      = 1'b0;
    logic [31:0] slow_lo  = 32'd0;
    logic [31:0] slow_hi  = 32'd0;
    logic [31:0] exp_q[$];
    logic [31:0] deliv_pc[$];
    int          deliv_cyc[$];
    logic [31:0] req_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    function automatic int lat_for(input logic [31:0] a);
        return (a >= slow_lo && a < slow_hi) ? 3 : 1;
    endfunction

    // ---------------- instruction memory model ----------------
    initial begin : imem_model
        logic        pending;
        int          cnt;
        logic [31:0] p_addr;
        logic        m_req;
        logic [31:0] m_addr;
        pending     = 1'b0;
        cnt         = 0;
        p_addr      = 32'd0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            m_req  = sel ? w_req : d_req;
            m_addr = sel ? w_addr : d_addr;
            if (!rst) begin
                pending     = 1'b0;
                imem_rvalid = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = instr_of(p_addr);
                        pending     = 1'b0;
                    end
                end
                if (m_req) begin
                    if ((pending || imem_rvalid) && !sel) overlap++;
                    req_log.push_back(m_addr);
                    pending = 1'b1;
                    cnt     = lat_for(m_addr);
                    p_addr  = m_addr;
                end
            end
        end
    end

    // Records each new IF/ID load of the main instance.
    initial begin : deliv_monitor
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst && d_valid && !stall_d) begin
                deliv_pc.push_back(d_pc);
                deliv_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic use_wrap);
        @(negedge clk);
        rst           = 1'b0;
        stall_d       = 1'b0;
        redirect_e    = 1'b0;
        redirect_pc_e = 32'd0;
        sel           = use_wrap;
        deliv_pc.delete();
        deliv_cyc.delete();
        req_log.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int k = 0;
        while (deliv_pc.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, deliv_pc.size(), n);
    endtask

    task automatic wait_req(input int n, input string tag);
        int k = 0;
        while (req_log.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, req_log.size(), n);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst           = 1'b0;
        stall_d       = 1'b0;
        redirect_e    = 1'b0;
        redirect_pc_e = 32'd0;

        // Reset values and startup; addresses 32..63 answer with latency 3.
        slow_lo = 32'd32;
        slow_hi = 32'd64;
        repeat (2) @(negedge clk);
        check("rst_req", d_req, 0);
        check("rst_addr", d_addr, 32'h0);
        check("rst_valid", d_valid, 0);
        check("rst_instr", d_instr, NOP);
        check("rst_pc", d_pc, 32'h0);
        check("rst_pc4", d_pc4, 32'h0);
        check("rst_state", d_state, ST_RESET);
        @(negedge clk);
        rst = 1'b1;
        check("start_noreq", d_req, 0);
        @(negedge clk);
        check("start_req", d_req, 1);
        check("start_addr", d_addr, 32'h0);
        @(negedge clk);
        check("start_wait_req", d_req, 0);
        check("start_wait_st", d_state, ST_WAIT);
        @(negedge clk);
        check("first_valid", d_valid, 1);
        check("first_instr", d_instr, 32'h0050_0093);
        check("first_pc", d_pc, 32'h0);
        check("first_pc4", d_pc4, 32'h4);
        check("second_req", d_req, 1);
        check("second_addr", d_addr, 32'h4);

        // Streaming: 8 at latency 1, then 8 at latency 3.
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        wait_deliv(16, "stream_count");
        for (int i = 0; i < 16; i++) check($sformatf("stream_pc%0d", i), deliv_pc[i], exp_q.pop_front());
        for (int i = 1; i < 16; i++)
            check($sformatf("stream_gap%0d", i), 32'(deliv_cyc[i] - deliv_cyc[i-1]), (i <= 7) ? 32'd2 : 32'd4);

        // Stall while the response for 0x10 arrives.
        slow_lo = 32'd0;
        slow_hi = 32'd0;
        do_reset(1'b0);
        wait_deliv(4, "stall_pre");
        check("stall_req_addr", d_addr, 32'h10);
        stall_d = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_state", d_state, ST_HOLD);
        check("stall_hold_pc", d_pc, 32'hC);
        check("stall_hold_valid", d_valid, 1);
        check("stall_noreq0", d_req, 0);
        @(negedge clk);
        check("stall_noreq1", d_req, 0);
        @(negedge clk);
        check("stall_noreq2", d_req, 0);
        check("stall_hold_pc2", d_pc, 32'hC);
        stall_d = 1'b0;
        @(negedge clk);
        check("skid_pc", d_pc, 32'h10);
        check("skid_pc4", d_pc4, 32'h14);
        check("skid_instr", d_instr, 32'h0000_1013);
        check("skid_valid", d_valid, 1);
        check("skid_next_req", d_req, 1);
        check("skid_next_addr", d_addr, 32'h14);

        // Redirect while the request for 0x20 (latency 3) is outstanding.
        slow_lo = 32'h20;
        slow_hi = 32'h24;
        do_reset(1'b0);
        wait_deliv(8, "redir_pre");
        check("redir_req_addr", d_addr, 32'h20);
        @(negedge clk);
        redirect_e    = 1'b1;
        redirect_pc_e = 32'h103;
        @(negedge clk);
        redirect_e = 1'b0;
        check("redir_valid", d_valid, 0);
        check("redir_instr", d_instr, NOP);
        check("redir_state", d_state, ST_DISC);
        check("redir_noreq", d_req, 0);
        check("redir_pcf", d_addr, 32'h100);
        @(negedge clk);
        check("redir_stale_rv", imem_rvalid, 1);
        check("redir_stale_noreq", d_req, 0);
        @(negedge clk);
        check("redir_tgt_req", d_req, 1);
        check("redir_tgt_addr", d_addr, 32'h100);
        repeat (2) @(negedge clk);
        check("redir_pc_d", d_pc, 32'h100);
        check("redir_instr_d", d_instr, 32'h0001_0013);
        check("redir_valid_d", d_valid, 1);
        check("redir_deliv_n", deliv_pc.size(), 9);
        check("redir_no_stale", deliv_pc[deliv_pc.size()-1], 32'h100);
        check("no_overlap", overlap, 0);

        // Flush beats stall while HOLD has the 0x10 response parked.
        slow_lo = 32'd0;
        slow_hi = 32'd0;
        do_reset(1'b0);
        wait_deliv(4, "flush_pre");
        stall_d = 1'b1;
        repeat (2) @(negedge clk);
        check("flush_in_hold", d_state, ST_HOLD);
        redirect_e    = 1'b1;
        redirect_pc_e = 32'h200;
        @(negedge clk);
        redirect_e = 1'b0;
        check("flush_valid", d_valid, 0);
        check("flush_instr", d_instr, NOP);
        check("flush_state", d_state, ST_ISSUE);
        check("flush_addr", d_addr, 32'h200);
        stall_d = 1'b0;
        wait_deliv(5, "flush_deliv");
        check("flush_first_pc", deliv_pc[deliv_pc.size()-1], 32'h200);
        check("flush_first_instr", d_instr, 32'h0002_0013);

        // PC wrap on the second instance, then asynchronous reset mid-WAIT.
        do_reset(1'b1);
        wait_req(3, "wrap_req_n");
        check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
        check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
        check("wrap_addr2", req_log[2], 32'h0000_0000);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", w_pc4, 32'h0000_0000);
        check("wrap_valid", w_valid, 1);
        stall_d = 1'b1;
        @(negedge clk);
        check("wrap_wait_state", w_state, ST_WAIT);
        check("wrap_wait_valid", w_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", w_req, 0);
        check("arst_valid", w_valid, 0);
        check("arst_addr", w_addr, 32'hFFFF_FFF8);
        check("arst_state", w_state, ST_RESET);
        check("arst_pc", w_pc, 32'h0);
        check("arst_instr", w_instr, NOP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the 5-stage RISC-V pipeline. It sits directly upstream of decode. It owns the fetch PC, issues one-outstanding requests to instruction memory over a req/rvalid handshake, and holds stalled responses in a skid register. It drives the IF/ID pipeline register and honours execute-stage redirects (taken branch or jump) with a flush that overrides stall.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value loaded into instr_d on reset/flush (addi x0,x0,0)
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request strobe, one cycle per request
- imem_addr  out  32  fetch address, valid while imem_req=1
- imem_rvalid  in  1  response strobe, at least 1 cycle after the request, never in the same cycle
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- stall_d  in  1  decode hazard stall: hold IF/ID
- redirect_e  in  1  execute-stage redirect (taken branch/jump)
- redirect_pc_e  in  32  redirect target; bits [1:0] ignored (forced 0)
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - pc_f (32): address of the next or outstanding fetch.
  - skid_instr/skid_pc (32 each).
  - state, one of RESET, ISSUE, WAIT, DISCARD, HOLD.
- imem_req=1 only in state ISSUE. imem_addr=pc_f at all times.
- At most one request is outstanding at any time.
- State transitions (redirect_e has top priority in every state; on redirect, pc_f<=redirect_pc_e & ~3):
  - RESET → ISSUE unconditionally.
  - ISSUE → WAIT. If redirect_e: → DISCARD, because the request is already issued.
  - WAIT:
    - rvalid & !stall_d: IF/ID <= {rdata, pc_f, pc_f+4}, valid_d<=1, pc_f<=pc_f+4, → ISSUE.
    - rvalid & stall_d: skid <= {rdata, pc_f}, pc_f<=pc_f+4, → HOLD.
    - rvalid & redirect_e: response dropped, → ISSUE.
    - !rvalid & redirect_e: → DISCARD.
    - Otherwise stay.
  - DISCARD: rvalid → response dropped, → ISSUE; otherwise stay. A further redirect only updates pc_f.
  - HOLD:
    - redirect_e: skid cleared, → ISSUE.
    - !stall_d: IF/ID <= {skid_instr, skid_pc, skid_pc+4}, valid_d<=1, → ISSUE.
    - Otherwise stay.
- IF/ID update rule, each cycle:
  - redirect_e: valid_d<=0, instr_d<=NOP_INSTR, even when stall_d=1.
  - else stall_d: all IF/ID outputs hold.
  - else valid_d<=1 if an instruction is delivered this cycle, otherwise valid_d<=0 (bubble, instr_d<=NOP_INSTR).
- Arithmetic: pc_f+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no error.

## Timing
- Reset values (asynchronous, while rst=0):
  - state=RESET, pc_f=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0
  - skid cleared
- First imem_req is asserted in the 2nd rising-edge cycle after rst deasserts (RESET→ISSUE).
- Latency: req in cycle t, rvalid in cycle t+L (L≥1), instruction on IF/ID outputs from cycle t+L+1.
- Next request follows in cycle t+L+1.
- Peak throughput is one instruction per L+1 cycles (2 cycles with a 1-cycle memory).
- Reset mid-operation: all state returns to reset values immediately. Any in-flight memory response after reset release is outside contract; the memory is reset together with this stage.
- Redirect in cycle t: valid_d=0 from t+1.
  - If no request is outstanding after cycle t, the target request issues at t+1.
  - Otherwise the target request issues the cycle after the stale rvalid.
- Stale responses never reach IF/ID.
- Simultaneous stall_d and redirect_e: the flush wins.

## Test plan
- Reset/startup: rst low 3 cycles, release; memory latency 1 returning 32'h00500093 → imem_req at cycle 2 with addr 0. Cycle 4: valid_d=1, instr_d=32'h00500093, pc_d=0, pc_plus4_d=4. Next req at addr 4.
- Streaming: 8 fetches with L=1, then 8 with L=3 → pc_d sequence 0,4,...,28 then 32,...,60. Gaps of exactly 1 and 3 bubble cycles respectively; never two requests outstanding.
- Stall/skid: assert stall_d for 4 cycles while a response for pc 0x10 arrives → IF/ID holds the previous instruction, no imem_req during HOLD. The cycle after stall_d drops: pc_d=0x10. The following req is at addr 0x14.
- Redirect with outstanding request: req at 0x20 with L=3, redirect_e to 0x103 in the cycle after the req → valid_d=0 next cycle. Response for 0x20 is dropped. The next req is at 0x100, in the cycle after the stale rvalid. pc_d=0x100 eventually.
- Flush beats stall: stall_d=1 and redirect_e=1 with target 0x200 in the same cycle while in HOLD → valid_d=0, instr_d=32'h00000013, skid discarded. After stall_d drops, the first delivered pc_d is 0x200.
- Wrap and async reset: RESET_PC=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Then pull rst low mid-WAIT, asynchronously between edges → imem_req=0 and valid_d=0 immediately, and imem_addr=RESET_PC.
